// File: rtl/pes_cg_ctrl_if.sv
// Activity request handshake between an upstream producer and pes_cg_ctrl.
// The producer holds act_valid until it sees act_valid & act_ready at a clock edge.
interface pes_cg_ctrl_if;
  logic act_valid;
  logic act_ready;

  modport master (output act_valid, input act_ready);
  modport slave  (input act_valid, output act_ready);
endinterface

// File: rtl/pes_cg_ctrl.sv
// Clock-gate enable controller feeding the pes_icg enable input.
//
// state  | meaning
// RUN    | clock live, accepting work, counting idle cycles toward gating
// GATED  | ICG enable low, waiting for activity or force_on
// WAKE   | enable re-asserted, ready withheld while the ICG enable pipe refills
//
// The ICG enable path is a posedge sample followed by a negedge latch, so
// WAKE_CYCLES must be at least 2 for the clock to be live when ready rises.
// All outputs are decoded from the state register only; there is no
// combinational path from any input to any output.
module pes_cg_ctrl #(
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  pes_cg_ctrl_if.slave     act,
  input  logic             force_on,
  input  logic             cnt_clr,
  output logic             en,
  output logic             gated,
  output logic [CNT_W-1:0] gate_cycles,
  output logic [7:0]       gate_events
);

  localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_GATED = 2'd1;
  localparam logic [1:0] ST_WAKE  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [IW-1:0] idle_cnt;
  logic [WW-1:0] wake_cnt;

  logic busy;
  logic idle_last;
  logic wake_last;
  logic go_gate;

  assign busy      = act.act_valid | force_on;
  assign idle_last = (idle_cnt == IDLE_LAST);
  assign wake_last = (wake_cnt == WAKE_LAST);
  assign go_gate   = (state == ST_RUN) && !busy && idle_last;

  // Next-state decode; an illegal encoding recovers through WAKE so the
  // clock is never left off without a refill period.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (go_gate) state_nxt = ST_GATED;
      end
      ST_GATED: begin
        if (busy) state_nxt = ST_WAKE;
      end
      ST_WAKE: begin
        if (wake_last) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_WAKE;
    endcase
  end

  // State register; reset lands in WAKE so en stays high through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_WAKE;
    else     state <= state_nxt;
  end

  // Idle run length in RUN, saturating at the gating threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (state == ST_RUN) begin
      if (busy)           idle_cnt <= '0;
      else if (!idle_last) idle_cnt <= idle_cnt + 1'b1;
    end else if (state == ST_WAKE && wake_last) begin
      idle_cnt <= '0;
    end
  end

  // WAKE dwell timer; restarted on every GATED->WAKE transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wake_cnt <= '0;
    end else if (state == ST_GATED) begin
      if (busy) wake_cnt <= '0;
    end else if (state == ST_WAKE) begin
      if (wake_last) wake_cnt <= '0;
      else           wake_cnt <= wake_cnt + 1'b1;
    end
  end

  // Saturating count of cycles spent gated; clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_cycles <= '0;
    end else if (cnt_clr) begin
      gate_cycles <= '0;
    end else if (state == ST_GATED && gate_cycles != {CNT_W{1'b1}}) begin
      gate_cycles <= gate_cycles + 1'b1;
    end
  end

  // Wrapping count of RUN->GATED transitions; clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_events <= '0;
    end else if (cnt_clr) begin
      gate_events <= '0;
    end else if (go_gate) begin
      gate_events <= gate_events + 8'd1;
    end
  end

  assign en            = (state != ST_GATED);
  assign gated         = (state == ST_GATED);
  assign act.act_ready = (state == ST_RUN);

endmodule
